// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcode, state, ALU and trap constants for the RV32I control path
// No ports: imported by op_classifier and cpu_stage_sequencer.
package cpu_defs_pkg;

   localparam logic [6:0] OPC_R  = 7'b0110011;
   localparam logic [6:0] OPC_I  = 7'b0010011;
   localparam logic [6:0] OPC_LD = 7'b0000011;
   localparam logic [6:0] OPC_ST = 7'b0100011;
   localparam logic [6:0] OPC_BR = 7'b1100011;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd7
   } state_t;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_BR    = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] TRAP_NONE    = 2'b00;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
   localparam logic [1:0] TRAP_IMEM    = 2'b10;
   localparam logic [1:0] TRAP_DMEM    = 2'b11;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_R    = 3'd1,
      OP_I    = 3'd2,
      OP_LD   = 3'd3,
      OP_ST   = 3'd4,
      OP_BR   = 3'd5
   } op_class_t;

endpackage

// File: rtl/cpu_stage_sequencer_if.sv
// rtl/cpu_stage_sequencer_if.sv - control/handshake bundle between the sequencer and the datapath
// Inputs to the sequencer: run, opcode, imem_ready, dmem_ready, branch_taken.
// Outputs from the sequencer: stage strobes, ALU controls, dmem request, state, trap, instr_count.
interface cpu_stage_sequencer_if #(
   parameter int COUNT_W = 32
);
   logic               run;
   logic [6:0]         opcode;
   logic               imem_ready;
   logic               dmem_ready;
   logic               branch_taken;
   logic               imem_req;
   logic               ir_we;
   logic               pc_we;
   logic               pc_sel;
   logic [1:0]         alu_op;
   logic               alu_src;
   logic               dmem_req;
   logic               dmem_we;
   logic               mem_to_reg;
   logic               reg_we;
   logic [2:0]         state;
   logic               trap;
   logic [1:0]         trap_cause;
   logic [COUNT_W-1:0] instr_count;

   modport master (
      input  run, opcode, imem_ready, dmem_ready, branch_taken,
      output imem_req, ir_we, pc_we, pc_sel, alu_op, alu_src, dmem_req, dmem_we,
             mem_to_reg, reg_we, state, trap, trap_cause, instr_count
   );

   modport slave (
      output run, opcode, imem_ready, dmem_ready, branch_taken,
      input  imem_req, ir_we, pc_we, pc_sel, alu_op, alu_src, dmem_req, dmem_we,
             mem_to_reg, reg_we, state, trap, trap_cause, instr_count
   );
endinterface

// File: rtl/op_classifier.sv
// rtl/op_classifier.sv - combinational opcode to instruction-class decode
// opcode   in  7  Instruction[6:0]
// op_class out    decoded class, OP_NONE when illegal
// illegal  out 1  opcode is not one of the supported RV32I classes
module op_classifier
   import cpu_defs_pkg::*;
(
   input  logic [6:0] opcode,
   output op_class_t  op_class,
   output logic       illegal
);

   always_comb begin
      op_class = OP_NONE;
      illegal  = 1'b0;
      case (opcode)
         OPC_R:   op_class = OP_R;
         OPC_I:   op_class = OP_I;
         OPC_LD:  op_class = OP_LD;
         OPC_ST:  op_class = OP_ST;
         OPC_BR:  op_class = OP_BR;
         default: illegal  = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_stage_sequencer.sv
// rtl/cpu_stage_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with trap and retire count
// clk  in  1  rising-edge clock
// rst  in  1  synchronous active-high reset
// bus  master modport of cpu_stage_sequencer_if (handshakes, stage strobes, debug state, trap, count)
module cpu_stage_sequencer
   import cpu_defs_pkg::*;
#(
   parameter int WAIT_LIMIT = 255,
   parameter int COUNT_W    = 32
)(
   input  logic                   clk,
   input  logic                   rst,
   cpu_stage_sequencer_if.master  bus
);

   localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

   state_t             state_q, state_d;
   op_class_t          op_class_q, op_class_d;
   logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [1:0]         cause_q, cause_d;
   logic [COUNT_W-1:0] count_q;
   logic               retire;
   logic               timeout;

   op_class_t dec_class;
   logic      dec_illegal;

   logic       imem_req, ir_we, pc_we, pc_sel, alu_src;
   logic       dmem_req, dmem_we, mem_to_reg, reg_we;
   logic [1:0] alu_op;

   op_classifier u_classifier (
      .opcode   (bus.opcode),
      .op_class (dec_class),
      .illegal  (dec_illegal)
   );

   // The cycle that finds wait_cnt at WAIT_LIMIT-1 is the WAIT_LIMIT-th waiting cycle.
   assign timeout = (wait_cnt_q == WCNT_W'(WAIT_LIMIT - 1));

   always_comb begin
      state_d    = state_q;
      op_class_d = op_class_q;
      cause_d    = cause_q;
      wait_cnt_d = '0;
      retire     = 1'b0;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      alu_op     = ALU_OP_ADD;
      alu_src    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      mem_to_reg = 1'b0;
      reg_we     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ready) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end else if (timeout) begin
               state_d = ST_TRAP;
               cause_d = TRAP_IMEM;
            end else begin
               wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
         end
         ST_DECODE: begin
            op_class_d = dec_class;
            if (dec_illegal) begin
               state_d = ST_TRAP;
               cause_d = TRAP_ILLEGAL;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (op_class_q)
               OP_R: begin
                  alu_op  = ALU_OP_FUNCT;
                  state_d = ST_WB;
               end
               OP_I: begin
                  alu_op  = ALU_OP_FUNCT;
                  alu_src = 1'b1;
                  state_d = ST_WB;
               end
               OP_LD, OP_ST: begin
                  alu_op  = ALU_OP_ADD;
                  alu_src = 1'b1;
                  state_d = ST_MEM;
               end
               OP_BR: begin
                  alu_op = ALU_OP_BR;
                  pc_we  = 1'b1;
                  pc_sel = bus.branch_taken;
                  retire = 1'b1;
               end
               // EXEC is only reachable with a legal class; treat anything else as illegal.
               default: begin
                  state_d = ST_TRAP;
                  cause_d = TRAP_ILLEGAL;
               end
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op_class_q == OP_ST);
            if (bus.dmem_ready) begin
               if (op_class_q == OP_ST) begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
               end else begin
                  state_d = ST_WB;
               end
            end else if (timeout) begin
               state_d = ST_TRAP;
               cause_d = TRAP_DMEM;
            end else begin
               wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
         end
         ST_WB: begin
            reg_we     = 1'b1;
            pc_we      = 1'b1;
            mem_to_reg = (op_class_q == OP_LD);
            retire     = 1'b1;
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: state_d = ST_IDLE;
      endcase

      if (retire) state_d = bus.run ? ST_FETCH : ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_class_q <= OP_NONE;
         wait_cnt_q <= '0;
         cause_q    <= TRAP_NONE;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         op_class_q <= op_class_d;
         wait_cnt_q <= wait_cnt_d;
         cause_q    <= cause_d;
         if (retire) count_q <= count_q + COUNT_W'(1);
      end
   end

   assign bus.imem_req    = imem_req;
   assign bus.ir_we       = ir_we;
   assign bus.pc_we       = pc_we;
   assign bus.pc_sel      = pc_sel;
   assign bus.alu_op      = alu_op;
   assign bus.alu_src     = alu_src;
   assign bus.dmem_req    = dmem_req;
   assign bus.dmem_we     = dmem_we;
   assign bus.mem_to_reg  = mem_to_reg;
   assign bus.reg_we      = reg_we;
   assign bus.state       = state_q;
   assign bus.trap        = (state_q == ST_TRAP);
   assign bus.trap_cause  = cause_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// tb/tb_cpu_stage_sequencer.sv - randomized and directed bench with a per-instruction cycle-plan model
module tb_cpu_stage_sequencer;

   localparam int WL = 4;

   typedef struct {
      logic        rst;
      logic        chk;
      logic        run;
      logic [6:0]  opcode;
      logic        imem_ready;
      logic        dmem_ready;
      logic        branch_taken;
      logic [2:0]  st;
      logic        imem_req;
      logic        ir_we;
      logic        pc_we;
      logic        pc_sel;
      logic [1:0]  alu_op;
      logic        alu_src;
      logic        dmem_req;
      logic        dmem_we;
      logic        mem_to_reg;
      logic        reg_we;
      logic        trap;
      logic [1:0]  cause;
      logic [31:0] cnt;
   } cyc_t;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_TRAP  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cpu_stage_sequencer_if #(.COUNT_W(32)) bus ();

   cpu_stage_sequencer #(.WAIT_LIMIT(WL), .COUNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   cyc_t        exp_q[$];
   cyc_t        cur;
   logic        chk_en = 1'b0;
   logic [31:0] mcnt = 0;
   logic [1:0]  mcause = 2'b00;
   int          mstate = M_IDLE;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int cls(input logic [6:0] o);
      case (o)
         7'b0110011: return 1;
         7'b0010011: return 2;
         7'b0000011: return 3;
         7'b0100011: return 4;
         7'b1100011: return 5;
         default:    return 0;
      endcase
   endfunction

   // Inputs not meaningful in a state are randomized: outputs must ignore them.
   function automatic cyc_t base(input logic [2:0] s);
      cyc_t c;
      c.rst = 1'b0;          c.chk = 1'b1;
      c.run = 1'($urandom);  c.opcode = 7'($urandom);
      c.imem_ready = 1'($urandom); c.dmem_ready = 1'($urandom);
      c.branch_taken = 1'($urandom);
      c.st = s;
      c.imem_req = 0; c.ir_we = 0; c.pc_we = 0; c.pc_sel = 0;
      c.alu_op = 2'b00; c.alu_src = 0; c.dmem_req = 0; c.dmem_we = 0;
      c.mem_to_reg = 0; c.reg_we = 0;
      c.trap = (s == 3'd7);
      c.cause = mcause;
      c.cnt = mcnt;
      return c;
   endfunction

   task automatic retire_instr(input logic rn);
      mcnt++;
      mstate = rn ? M_FETCH : M_IDLE;
   endtask

   task automatic plan_reset(input int n);
      cyc_t c;
      for (int k = 0; k < n; k++) begin
         c = base(3'd0);
         c.rst = 1'b1;
         c.chk = 1'b0;
         exp_q.push_back(c);
      end
      mcnt = 0;
      mcause = 2'b00;
      mstate = M_IDLE;
   endtask

   task automatic plan_idle(input int n);
      cyc_t c;
      for (int k = 0; k <= n; k++) begin
         c = base(3'd0);
         c.run = (k == n);
         exp_q.push_back(c);
      end
      mstate = M_FETCH;
   endtask

   task automatic plan_hold(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(base(3'd7));
   endtask

   // Expected cycles of one instruction starting at FETCH: iw/dw are wait cycles before ready.
   task automatic plan_instr(input logic [6:0] opc, input int iw, input int dw,
                             input logic tk, input logic rn);
      cyc_t c;
      int   k_cls;
      for (int k = 0; k <= iw && k < WL; k++) begin
         c = base(3'd1);
         c.imem_req = 1'b1;
         c.imem_ready = (k == iw);
         c.ir_we = (k == iw);
         exp_q.push_back(c);
      end
      if (iw >= WL) begin mcause = 2'b10; mstate = M_TRAP; return; end
      c = base(3'd2);
      c.opcode = opc;
      exp_q.push_back(c);
      k_cls = cls(opc);
      if (k_cls == 0) begin mcause = 2'b01; mstate = M_TRAP; return; end
      c = base(3'd3);
      case (k_cls)
         1:       begin c.alu_op = 2'b10; c.alu_src = 1'b0; end
         2:       begin c.alu_op = 2'b10; c.alu_src = 1'b1; end
         3, 4:    begin c.alu_op = 2'b00; c.alu_src = 1'b1; end
         default: begin c.alu_op = 2'b01; c.alu_src = 1'b0; end
      endcase
      if (k_cls == 5) begin
         c.branch_taken = tk; c.pc_we = 1'b1; c.pc_sel = tk; c.run = rn;
         exp_q.push_back(c);
         retire_instr(rn);
         return;
      end
      exp_q.push_back(c);
      if (k_cls == 3 || k_cls == 4) begin
         for (int k = 0; k <= dw && k < WL; k++) begin
            c = base(3'd4);
            c.dmem_req = 1'b1;
            c.dmem_we = (k_cls == 4);
            c.dmem_ready = (k == dw);
            if (k == dw && k_cls == 4) begin c.pc_we = 1'b1; c.run = rn; end
            exp_q.push_back(c);
         end
         if (dw >= WL) begin mcause = 2'b11; mstate = M_TRAP; return; end
         if (k_cls == 4) begin retire_instr(rn); return; end
      end
      c = base(3'd5);
      c.reg_we = 1'b1; c.pc_we = 1'b1; c.mem_to_reg = (k_cls == 3); c.run = rn;
      exp_q.push_back(c);
      retire_instr(rn);
   endtask

   task automatic run_q();
      cyc_t c;
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         @(posedge clk);
         #1;
         rst              = c.rst;
         bus.run          = c.run;
         bus.opcode       = c.opcode;
         bus.imem_ready   = c.imem_ready;
         bus.dmem_ready   = c.dmem_ready;
         bus.branch_taken = c.branch_taken;
         cur              = c;
         chk_en           = c.chk;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("state",       32'(bus.state),       32'(cur.st));
         check("imem_req",    32'(bus.imem_req),    32'(cur.imem_req));
         check("ir_we",       32'(bus.ir_we),       32'(cur.ir_we));
         check("pc_we",       32'(bus.pc_we),       32'(cur.pc_we));
         check("pc_sel",      32'(bus.pc_sel),      32'(cur.pc_sel));
         check("alu_op",      32'(bus.alu_op),      32'(cur.alu_op));
         check("alu_src",     32'(bus.alu_src),     32'(cur.alu_src));
         check("dmem_req",    32'(bus.dmem_req),    32'(cur.dmem_req));
         check("dmem_we",     32'(bus.dmem_we),     32'(cur.dmem_we));
         check("mem_to_reg",  32'(bus.mem_to_reg),  32'(cur.mem_to_reg));
         check("reg_we",      32'(bus.reg_we),      32'(cur.reg_we));
         check("trap",        32'(bus.trap),        32'(cur.trap));
         check("trap_cause",  32'(bus.trap_cause),  32'(cur.cause));
         check("instr_count", bus.instr_count,      cur.cnt);
      end
   end

   initial begin
      int   qs;
      int   n;
      logic [11:0] sts;
      logic [3:0]  rw;
      logic [6:0]  opc;

      bus.run = 1'b0; bus.opcode = '0; bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0; bus.branch_taken = 1'b0;

      // R-type with zero-wait memories.
      plan_reset(2);
      plan_idle(0);
      qs = exp_q.size();
      plan_instr(7'b0110011, 0, 0, 1'b0, 1'b1);
      sts = {exp_q[qs].st, exp_q[qs+1].st, exp_q[qs+2].st, exp_q[qs+3].st};
      rw  = {exp_q[qs].reg_we, exp_q[qs+1].reg_we, exp_q[qs+2].reg_we, exp_q[qs+3].reg_we};
      check("pin_r_states", 32'(sts), 32'h29D);
      check("pin_r_reg_we", 32'(rw), 32'h1);
      check("pin_r_alu_op", 32'(exp_q[qs+2].alu_op), 32'h2);
      run_q();

      // Load, dmem_ready on the 4th MEM cycle.
      qs = exp_q.size();
      plan_instr(7'b0000011, 0, 3, 1'b0, 1'b1);
      n = 0;
      for (int i = qs; i < exp_q.size(); i++) if (exp_q[i].dmem_req) n++;
      check("pin_ld_dmem_cycles", 32'(n), 32'd4);
      check("pin_ld_len", 32'(exp_q.size() - qs), 32'd8);
      check("pin_ld_wb", 32'({exp_q[qs+7].mem_to_reg, exp_q[qs+7].reg_we}), 32'h3);
      check("pin_cnt_after_r", exp_q[qs].cnt, 32'd1);
      run_q();

      // Taken branch.
      qs = exp_q.size();
      plan_instr(7'b1100011, 0, 0, 1'b1, 1'b1);
      check("pin_br_len", 32'(exp_q.size() - qs), 32'd3);
      check("pin_br_exec", 32'({exp_q[qs+2].pc_we, exp_q[qs+2].pc_sel, exp_q[qs+2].alu_op}), 32'hD);
      run_q();

      // run dropped across an R-type retirement, then restarted with an I-type.
      plan_instr(7'b0110011, 0, 0, 1'b0, 1'b0);
      plan_idle(1);
      qs = exp_q.size();
      plan_instr(7'b0010011, 1, 0, 1'b0, 1'b1);
      check("pin_cnt_continues", exp_q[qs].cnt, 32'd4);
      run_q();

      // Illegal opcode traps and holds until reset.
      qs = exp_q.size();
      plan_instr(7'b1111111, 0, 0, 1'b0, 1'b1);
      check("pin_illegal_len", 32'(exp_q.size() - qs), 32'd2);
      plan_hold(20);
      check("pin_illegal_cause", 32'(exp_q[qs+2].cause), 32'd1);
      run_q();
      plan_reset(1);
      plan_idle(0);

      // imem never ready: trap after WL fetch cycles.
      qs = exp_q.size();
      plan_instr(7'b0110011, 9, 0, 1'b0, 1'b1);
      check("pin_imem_timeout_len", 32'(exp_q.size() - qs), 32'd4);
      plan_hold(3);
      run_q();
      plan_reset(1);
      plan_idle(0);

      // Store stalled in MEM, reset on its second MEM cycle.
      qs = exp_q.size();
      plan_instr(7'b0100011, 0, 3, 1'b0, 1'b1);
      while (exp_q.size() > qs + 4) void'(exp_q.pop_back());
      plan_reset(1);
      plan_idle(2);
      run_q();

      // Randomized instruction stream.
      for (int it = 0; it < 300; it++) begin
         if (mstate == M_IDLE) begin
            plan_idle($urandom_range(0, 2));
         end else if (mstate == M_TRAP) begin
            plan_hold($urandom_range(1, 4));
            plan_reset($urandom_range(1, 2));
            plan_idle($urandom_range(0, 1));
         end else begin
            case ($urandom_range(0, 6))
               0:       opc = 7'b0110011;
               1:       opc = 7'b0010011;
               2:       opc = 7'b0000011;
               3:       opc = 7'b0100011;
               4:       opc = 7'b1100011;
               5:       opc = 7'b0000011;
               default: opc = 7'($urandom);
            endcase
            plan_instr(opc,
                       ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5),
                       ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5),
                       1'($urandom),
                       ($urandom_range(0, 3) != 0));
         end
         run_q();
      end

      @(posedge clk);
      #1 chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
